// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// single-port memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
        output if_rdata, if_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
        input  if_rdata, if_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory. Data wins
// ties up to MAX_STREAK grants; a watchdog closes hung transactions with err.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memCmd_t;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] rdata;
    } portRsp_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

    state_t            state, stateNxt;
    memCmd_t           cmd, cmdNxt;
    portRsp_t          ifRsp, ifRspNxt, dRsp, dRspNxt;
    logic              ownerD, ownerDNxt;
    logic              errQ, errNxt;
    logic [3:0]        streak, streakNxt;
    logic [7:0]        wdog, wdogNxt;
    logic              grantD;
    logic [DATA_W-1:0] rspData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cmd    <= '0;
            ifRsp  <= '0;
            dRsp   <= '0;
            ownerD <= 1'b0;
            errQ   <= 1'b0;
            streak <= '0;
            wdog   <= '0;
        end else begin
            state  <= stateNxt;
            cmd    <= cmdNxt;
            ifRsp  <= ifRspNxt;
            dRsp   <= dRspNxt;
            ownerD <= ownerDNxt;
            errQ   <= errNxt;
            streak <= streakNxt;
            wdog   <= wdogNxt;
        end
    end

    always_comb begin
        stateNxt       = state;
        cmdNxt         = cmd;
        cmdNxt.req     = 1'b0;
        ifRspNxt       = ifRsp;
        ifRspNxt.ready = 1'b0;
        dRspNxt        = dRsp;
        dRspNxt.ready  = 1'b0;
        ownerDNxt      = ownerD;
        errNxt         = 1'b0;
        streakNxt      = streak;
        wdogNxt        = wdog;
        rspData        = '0;
        // A full streak hands the next contested slot to fetch.
        grantD         = bus.d_req && !(bus.if_req && streak == STREAK_MAX);

        unique case (state)
            IDLE: begin
                if (!bus.if_req) streakNxt = '0;
                if (bus.if_req || bus.d_req) begin
                    stateNxt   = WAIT;
                    wdogNxt    = '0;
                    ownerDNxt  = grantD;
                    cmdNxt.req = 1'b1;
                    if (grantD) begin
                        cmdNxt.we    = bus.d_we;
                        cmdNxt.addr  = bus.d_addr;
                        cmdNxt.wdata = bus.d_wdata;
                        if (bus.if_req) streakNxt = streak + 4'd1;
                    end else begin
                        cmdNxt.we    = 1'b0;
                        cmdNxt.addr  = bus.if_addr;
                        cmdNxt.wdata = '0;
                        streakNxt    = '0;
                    end
                end
            end
            WAIT: begin
                // mem_valid on the final watchdog edge still counts as success.
                if (bus.mem_valid || wdog == WDOG_LAST) begin
                    stateNxt = DONE;
                    errNxt   = !bus.mem_valid;
                    rspData  = (bus.mem_valid && !cmd.we) ? bus.mem_rdata : '0;
                    if (ownerD) begin
                        dRspNxt.ready  = 1'b1;
                        dRspNxt.rdata  = rspData;
                    end else begin
                        ifRspNxt.ready = 1'b1;
                        ifRspNxt.rdata = rspData;
                    end
                end else begin
                    wdogNxt = wdog + 8'd1;
                end
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.mem_req   = cmd.req;
    assign bus.mem_we    = cmd.we;
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.if_ready  = ifRsp.ready;
    assign bus.if_rdata  = ifRsp.rdata;
    assign bus.d_ready   = dRsp.ready;
    assign bus.d_rdata   = dRsp.rdata;
    assign bus.err       = errQ;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run, all checked against a
// transaction-level model of grants, latencies and responses.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // model of the outstanding transaction
    bit          busy = 1'b0;
    bit          ownD;
    bit          expWe;
    int          issue;
    int          lat;
    logic [31:0] expRd;
    int          doneCyc = -10;
    int          streakM = 0;
    bit          grantLog[$];

    // stimulus knobs
    bit          randLat = 1'b0;
    int          nextLat = 2;
    logic [31:0] nextRdata = 32'h0;
    bit          lateValid = 1'b0;
    bit          spurious = 1'b0;
    bit          autoI = 1'b0, autoD = 1'b0;
    int unsigned rateI = 0, rateD = 0, holdPct = 0, dropPct = 0;
    bit          holdI = 1'b0, holdD = 1'b0;
    bit          sawI, sawD;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check32({tag, "_flags"}, 32'({bus.if_ready, bus.d_ready, bus.err, bus.mem_req, bus.mem_we}), 32'd0);
        check32({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        check32({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
        check32({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check32({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    task automatic grant();
        bit expD;
        int r;
        expD = bus.d_req && !(bus.if_req && streakM == MS);
        check32("grant_addr", bus.mem_addr, expD ? bus.d_addr : bus.if_addr);
        check1("grant_we", bus.mem_we, expD ? bus.d_we : 1'b0);
        check32("grant_wdata", bus.mem_wdata, expD ? bus.d_wdata : 32'd0);
        grantLog.push_back(expD);
        if (!expD) streakM = 0;
        else if (bus.if_req) streakM = streakM + 1;
        else streakM = 0;
        busy  = 1'b1;
        ownD  = expD;
        expWe = expD && bus.d_we;
        issue = cyc;
        if (randLat) begin
            r     = int'($urandom_range(0, 9));
            lat   = (r == 0) ? 0 : (r == 1) ? TO : int'($urandom_range(1, 6));
            expRd = $urandom;
        end else begin
            lat   = nextLat;
            expRd = nextRdata;
        end
    endtask

    task automatic requesters();
        if (sawI) begin
            if ($urandom_range(0, 99) < holdPct) holdI = 1'b1;
            else bus.if_req = 1'b0;
        end else if (holdI) begin
            bus.if_req = 1'b0;
            holdI = 1'b0;
        end else if (busy && !ownD && bus.if_req && $urandom_range(0, 99) < dropPct) begin
            bus.if_req = 1'b0;
        end else if (autoI && !bus.if_req && !(busy && !ownD) && $urandom_range(0, 99) < rateI) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom;
        end
        if (sawD) begin
            if ($urandom_range(0, 99) < holdPct) holdD = 1'b1;
            else bus.d_req = 1'b0;
        end else if (holdD) begin
            bus.d_req = 1'b0;
            holdD = 1'b0;
        end else if (busy && ownD && bus.d_req && $urandom_range(0, 99) < dropPct) begin
            bus.d_req = 1'b0;
        end else if (autoD && !bus.d_req && !(busy && ownD) && $urandom_range(0, 99) < rateD) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end
    endtask

    // One cycle: observe at the falling edge, then drive memory and requesters.
    task automatic step();
        logic [31:0] rdExp;
        @(negedge clk);
        cyc++;
        sawI = bus.if_ready;
        sawD = bus.d_ready;
        if (busy) begin
            check1("mem_req_single", bus.mem_req, 1'b0);
            if (cyc == issue + ((lat == 0) ? TO : lat)) begin
                rdExp = (lat == 0 || expWe) ? 32'd0 : expRd;
                check1("if_ready", bus.if_ready, !ownD);
                check1("d_ready", bus.d_ready, ownD);
                check1("err", bus.err, lat == 0);
                if (ownD) check32("d_rdata", bus.d_rdata, rdExp);
                else check32("if_rdata", bus.if_rdata, rdExp);
                busy    = 1'b0;
                doneCyc = cyc;
            end else begin
                check32("early_ready", 32'({bus.if_ready, bus.d_ready, bus.err}), 32'd0);
            end
        end else begin
            check32("idle_ready", 32'({bus.if_ready, bus.d_ready, bus.err}), 32'd0);
            check1("mem_req", bus.mem_req, (cyc >= doneCyc + 2) && (bus.if_req || bus.d_req));
            if (bus.mem_req) grant();
        end
        bus.mem_valid = (busy && lat != 0 && cyc - issue == lat - 1) || lateValid ||
                        (!busy && spurious && $urandom_range(0, 3) == 0);
        bus.mem_rdata = (busy && bus.mem_valid) ? expRd : $urandom;
        requesters();
    endtask

    task automatic serve(input int maxCyc);
        int n;
        n = 0;
        while ((busy || bus.if_req || bus.d_req || holdI || holdD) && n < maxCyc) begin
            step();
            n++;
        end
        check1("serve_bound", n < maxCyc, 1'b1);
    endtask

    initial begin
        logic [5:0] pat;
        int n;
        reset = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkZero("por");
        reset = 1'b1;

        // 1: reset while a load to 0x40 is outstanding
        nextLat = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
        n = 0;
        while (!busy && n < 10) begin step(); n++; end
        check1("t1_granted", busy, 1'b1);
        step();
        #2 reset = 1'b0;
        #1 checkZero("t1_reset");
        bus.d_req = 1'b0; busy = 1'b0; streakM = 0;
        step();
        reset = 1'b1;
        lateValid = 1'b1;
        step();
        lateValid = 1'b0;
        step();
        step();

        // 2: single fetch, L=2
        nextLat = 2; nextRdata = 32'h0010_0093;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        serve(20);
        check32("t2_if_rdata", bus.if_rdata, 32'h0010_0093);

        // 3: simultaneous fetch and store
        grantLog.delete();
        nextLat = 3; nextRdata = 32'hCAFE_0001;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        serve(40);
        check32("t3_order", 32'({grantLog[0], grantLog[1]}), 32'b10);
        check32("t3_d_rdata", bus.d_rdata, 32'd0);

        // 4: streak limit with both ports always requesting
        grantLog.delete();
        nextLat = 1;
        autoI = 1'b1; autoD = 1'b1; rateI = 100; rateD = 100;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        n = 0;
        while (grantLog.size() < 6 && n < 200) begin
            step();
            n++;
            if (bus.mem_req && grantLog.size() == 5) check32("t4_streak_clr", 32'(dut.streak), 32'd0);
        end
        autoI = 1'b0; autoD = 1'b0;
        serve(60);
        pat = '0;
        for (int i = 0; i < 6 && i < grantLog.size(); i++) pat[5-i] = grantLog[i];
        check32("t4_pattern", 32'(pat), 32'b111101);

        // 5: load never answered
        nextLat = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        serve(40);
        check32("t5_d_rdata", bus.d_rdata, 32'd0);

        // 6: fetch held through its ready cycle
        nextLat = 1; nextRdata = 32'h0000_0513;
        holdPct = 100;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        serve(30);
        holdPct = 0;
        repeat (3) step();

        // randomized traffic
        randLat = 1'b1; spurious = 1'b1;
        autoI = 1'b1; autoD = 1'b1; rateI = 30; rateD = 50; holdPct = 30; dropPct = 5;
        for (int i = 0; i < 800; i++) step();
        autoI = 1'b0; autoD = 1'b0; spurious = 1'b0; dropPct = 0;
        serve(100);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
